// File: rtl/saturn_periph_pkg.sv
// Shared definitions for Saturn peripheral-port devices: FSM states, mouse ID, frame length.
package saturn_periph_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_HOST = 2'd2,
    ABORT     = 2'd3
  } state_e;

  // Shuttle Mouse identification nibbles, sent first in every frame.
  localparam logic [15:0] MOUSE_ID = {4'h0, 4'hB, 4'hF, 4'hF};

  localparam int         NIBBLES  = 10;
  localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

  // Returns ID nibble i (0..3) of MOUSE_ID, most significant first.
  function automatic logic [3:0] id_nibble(input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = MOUSE_ID[15:12];
      2'd1:    n = MOUSE_ID[11:8];
      2'd2:    n = MOUSE_ID[7:4];
      2'd3:    n = MOUSE_ID[3:0];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/periph_sync.sv
// Two-flop synchroniser for an asynchronous port pin plus a third flop for edge detection.
module periph_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Shift the pin through the synchroniser chain.
  always_comb begin
    s1_d = pin;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser registers, preset to the idle pin level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/saturn_mouse_port.sv
// Saturn Shuttle Mouse port: answers the TH/TR/TL handshake with a 10-nibble
// snapshot of the PS/2 accumulator and requests an accumulator clear afterwards.
module saturn_mouse_port
  import saturn_periph_pkg::*;
#(
  parameter int unsigned  ACK_DLY = 8,
  parameter logic [15:0]  TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       th,
  input  logic       tr,
  input  logic [3:0] flags,
  input  logic [3:0] buttons,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [3:0] d,
  output logic       tl,
  output logic       reset_acc,
  output logic       busy
);

  localparam logic [15:0] DLY_LOAD = 16'(ACK_DLY - 1);
  localparam logic [15:0] TO_LAST  = TIMEOUT - 16'd1;

  logic th_rise, th_fall, tr_rise, tr_fall, tr_edge;

  periph_sync #(.RST_VAL(1'b1)) u_th_sync (
    .clk(clk), .reset_n(reset_n), .pin(th), .rise(th_rise), .fall(th_fall)
  );
  periph_sync #(.RST_VAL(1'b1)) u_tr_sync (
    .clk(clk), .reset_n(reset_n), .pin(tr), .rise(tr_rise), .fall(tr_fall)
  );

  assign tr_edge = tr_rise | tr_fall;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] dly_q, dly_d;
  logic [15:0] to_q, to_d;
  logic [23:0] snap_q, snap_d;   // {flags, buttons, x, y} captured at select
  logic        pend_q, pend_d;   // one TR request latched during ACK
  logic        done_q, done_d;   // accumulator clear already requested this frame
  logic        rpend_q, rpend_d; // clear request armed by the nibble-9 ack
  logic [3:0]  d_q, d_d;
  logic        tl_q, tl_d;
  logic        reset_acc_q, reset_acc_d;
  logic        busy_q, busy_d;

  // Selects frame nibble i from the ID constant or the captured snapshot.
  function automatic logic [3:0] frame_nibble(input logic [3:0] i, input logic [23:0] s);
    logic [3:0] n;
    case (i)
      4'd0, 4'd1, 4'd2, 4'd3: n = id_nibble(i[1:0]);
      4'd4:    n = s[23:20];
      4'd5:    n = s[19:16];
      4'd6:    n = s[15:12];
      4'd7:    n = s[11:8];
      4'd8:    n = s[7:4];
      4'd9:    n = s[3:0];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Handshake FSM: next state, counters, snapshot and port outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    to_d        = to_q;
    snap_d      = snap_q;
    pend_d      = pend_q;
    done_d      = done_q;
    rpend_d     = 1'b0;
    d_d         = d_q;
    tl_d        = tl_q;
    reset_acc_d = rpend_q;

    if (th_rise && (state_q != IDLE)) begin
      // Deselect overrides any handshake activity.
      state_d = IDLE;
      idx_d   = 4'd0;
      dly_d   = 16'd0;
      to_d    = 16'd0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      d_d     = 4'h0;
      tl_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          d_d  = 4'h0;
          tl_d = 1'b1;
          if (th_fall) begin
            snap_d  = {flags, buttons, x, y};
            idx_d   = 4'd0;
            d_d     = frame_nibble(4'd0, snap_q);
            dly_d   = DLY_LOAD;
            pend_d  = 1'b0;
            done_d  = 1'b0;
            state_d = ACK;
          end else begin
            idx_d = 4'd0;
          end
        end
        ACK: begin
          if (tr_edge) begin
            pend_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
          if (dly_q == 16'd0) begin
            tl_d = ~tl_q;
            if ((idx_q == LAST_IDX) && !done_q) begin
              rpend_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              rpend_d = 1'b0;
            end
            to_d    = 16'd0;
            state_d = WAIT_HOST;
          end else begin
            dly_d = dly_q - 16'd1;
          end
        end
        WAIT_HOST: begin
          if (tr_edge || pend_q) begin
            // Service one request; if a fresh edge coincides with a pending one, keep it.
            pend_d = pend_q & tr_edge;
            if (idx_q < LAST_IDX) begin
              idx_d = idx_q + 4'd1;
              d_d   = frame_nibble(idx_q + 4'd1, snap_q);
            end else begin
              d_d = 4'h0;
            end
            dly_d   = DLY_LOAD;
            state_d = ACK;
          end else if (to_q == TO_LAST) begin
            state_d = ABORT;
          end else begin
            to_d = to_q + 16'd1;
          end
        end
        ABORT: begin
          pend_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      dly_q       <= 16'd0;
      to_q        <= 16'd0;
      snap_q      <= 24'd0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      rpend_q     <= 1'b0;
      d_q         <= 4'h0;
      tl_q        <= 1'b1;
      reset_acc_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      to_q        <= to_d;
      snap_q      <= snap_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      rpend_q     <= rpend_d;
      d_q         <= d_d;
      tl_q        <= tl_d;
      reset_acc_q <= reset_acc_d;
      busy_q      <= busy_d;
    end
  end

  assign d         = d_q;
  assign tl        = tl_q;
  assign reset_acc = reset_acc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_saturn_mouse_port.sv
// Self-checking bench for saturn_mouse_port: table-driven full read, hand-written
// corner sequences and randomized frames checked against a frame model.
module tb_saturn_mouse_port;

  localparam int ACK = 4;
  localparam int LAT = 3 + ACK;

  logic       clk = 1'b0;
  logic       reset_n, th, tr;
  logic [3:0] flags, buttons;
  logic [7:0] x, y;
  logic [3:0] d;
  logic       tl, reset_acc, busy;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  saturn_mouse_port #(.ACK_DLY(ACK), .TIMEOUT(16'd100)) dut (
    .clk(clk), .reset_n(reset_n), .th(th), .tr(tr),
    .flags(flags), .buttons(buttons), .x(x), .y(y),
    .d(d), .tl(tl), .reset_acc(reset_acc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count reset_acc pulses (sampled mid-cycle).
  always @(negedge clk) begin
    if (reset_acc === 1'b1) pulses = pulses + 1;
  end

  typedef struct {
    bit         act;      // 0: drop th, 1: toggle tr
    bit         set_x_en;
    logic [7:0] set_x;
    logic [3:0] exp_d;
    logic       exp_tl;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tl(input int budget, output int n, output logic ok);
    logic old;
    old = tl;
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n = n + 1;
      if (tl !== old) ok = 1'b1;
    end
  endtask

  // Frame model: ID 0BFF followed by flags, buttons, x, y as nibbles, MSB first.
  function automatic logic [3:0] model_nib(input logic [3:0] f, input logic [3:0] b,
                                           input logic [7:0] xx, input logic [7:0] yy,
                                           input int i);
    logic [39:0] w;
    w = {16'h0BFF, f, b, xx, yy};
    return 4'(w >> (4 * (9 - i)));
  endfunction

  // One host step (th fall or tr toggle) followed by the ack check.
  task automatic step(input bit is_tr, input string name, input logic [3:0] exp_d);
    int n;
    logic ok;
    if (is_tr) tr = ~tr;
    else th = 1'b0;
    wait_tl(40, n, ok);
    chk({name, " ack"}, {31'd0, ok}, 32'd1);
    chk({name, " latency"}, n, LAT);
    chk({name, " d"}, {28'd0, d}, {28'd0, exp_d});
  endtask

  initial begin
    int n, p0;
    logic ok;
    logic tl_hold;
    logic [3:0] sf, sb;
    logic [7:0] sx, sy;

    tbl[0] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 4'hB, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 4'hF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 4'hF, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 4'h5, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 4'h3, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 4'h3, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 4'hC, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 4'hF, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 4'h0, 1'b1};

    reset_n = 1'b0; th = 1'b1; tr = 1'b0;
    flags = 4'b0101; buttons = 4'b0011; x = 8'h3C; y = 8'hF0;

    // Reset and idle behaviour.
    tick(2);
    chk("rst d", {28'd0, d}, 32'd0);
    chk("rst tl", {31'd0, tl}, 32'd1);
    chk("rst reset_acc", {31'd0, reset_acc}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tr = ~tr;
      tick(2);
    end
    tick(10);
    chk("idle d", {28'd0, d}, 32'd0);
    chk("idle tl", {31'd0, tl}, 32'd1);
    chk("idle busy", {31'd0, busy}, 32'd0);
    chk("idle pulses", pulses, 32'd0);

    // Table-driven full read with a mid-frame change of x.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].set_x_en) x = tbl[i].set_x;
      if (tbl[i].act) tr = ~tr;
      else th = 1'b0;
      wait_tl(40, n, ok);
      chk($sformatf("full%0d ack", i), {31'd0, ok}, 32'd1);
      chk($sformatf("full%0d latency", i), n, LAT);
      chk($sformatf("full%0d d", i), {28'd0, d}, {28'd0, tbl[i].exp_d});
      chk($sformatf("full%0d tl", i), {31'd0, tl}, {31'd0, tbl[i].exp_tl});
      chk($sformatf("full%0d busy", i), {31'd0, busy}, 32'd1);
    end
    chk("full rst_acc at tl", {31'd0, reset_acc}, 32'd0);
    tick(1);
    chk("full rst_acc +1", {31'd0, reset_acc}, 32'd1);
    tick(1);
    chk("full rst_acc +2", {31'd0, reset_acc}, 32'd0);
    chk("full pulse count", pulses - p0, 32'd1);
    th = 1'b1;
    tick(3);
    chk("desel d", {28'd0, d}, 32'd0);
    chk("desel tl", {31'd0, tl}, 32'd1);
    chk("desel busy", {31'd0, busy}, 32'd0);
    tick(4);

    // Early deselect after nibble 5 (x now 8'h11).
    p0 = pulses;
    for (int i = 0; i < 6; i++)
      step(i != 0, $sformatf("early%0d", i), model_nib(flags, buttons, x, y, i));
    th = 1'b1;
    tick(3);
    chk("early tl", {31'd0, tl}, 32'd1);
    chk("early d", {28'd0, d}, 32'd0);
    chk("early busy", {31'd0, busy}, 32'd0);
    tick(4);
    chk("early no pulse", pulses - p0, 32'd0);

    // Restart, then a slow host, then a stall past the timeout.
    step(1'b0, "restart0", 4'h0);
    chk("restart tl", {31'd0, tl}, 32'd0);
    step(1'b1, "to1", 4'hB);
    tick(90);
    step(1'b1, "to2 slow", 4'hF);
    tl_hold = tl;
    tick(110);
    for (int k = 0; k < 2; k++) begin
      tr = ~tr;
      tick(LAT + 10);
      chk($sformatf("abort%0d d", k), {28'd0, d}, 32'hF);
      chk($sformatf("abort%0d tl", k), {31'd0, tl}, {31'd0, tl_hold});
      chk($sformatf("abort%0d busy", k), {31'd0, busy}, 32'd1);
    end
    th = 1'b1;
    tick(3);
    chk("abort idle tl", {31'd0, tl}, 32'd1);
    chk("abort idle d", {28'd0, d}, 32'd0);
    chk("abort idle busy", {31'd0, busy}, 32'd0);
    tick(4);
    chk("abort no pulse", pulses - p0, 32'd0);

    // Overrun during ACK and surplus acks after nibble 9.
    flags = 4'hA; buttons = 4'hC; x = 8'h7E; y = 8'h81;
    p0 = pulses;
    for (int i = 0; i < 4; i++)
      step(i != 0, $sformatf("ovr%0d", i), model_nib(4'hA, 4'hC, 8'h7E, 8'h81, i));
    tr = ~tr;
    tick(2);
    tr = ~tr;
    tick(1);
    tr = ~tr;
    wait_tl(40, n, ok);
    chk("ovr first ack", {31'd0, ok}, 32'd1);
    chk("ovr first d", {28'd0, d}, {28'd0, model_nib(4'hA, 4'hC, 8'h7E, 8'h81, 4)});
    wait_tl(40, n, ok);
    chk("ovr pending ack", {31'd0, ok}, 32'd1);
    chk("ovr pending d", {28'd0, d}, {28'd0, model_nib(4'hA, 4'hC, 8'h7E, 8'h81, 5)});
    tl_hold = tl;
    tick(30);
    chk("ovr dropped tl", {31'd0, tl}, {31'd0, tl_hold});
    chk("ovr dropped d", {28'd0, d}, {28'd0, model_nib(4'hA, 4'hC, 8'h7E, 8'h81, 5)});
    for (int i = 6; i < 10; i++)
      step(1'b1, $sformatf("ovr%0d", i), model_nib(4'hA, 4'hC, 8'h7E, 8'h81, i));
    step(1'b1, "surplus1", 4'h0);
    step(1'b1, "surplus2", 4'h0);
    tick(5);
    chk("surplus pulses", pulses - p0, 32'd1);
    th = 1'b1;
    tick(7);

    // Reset in the middle of a frame.
    p0 = pulses;
    for (int i = 0; i < 3; i++)
      step(i != 0, $sformatf("mid%0d", i), model_nib(flags, buttons, x, y, i));
    reset_n = 1'b0;
    th = 1'b1;
    tick(1);
    chk("midrst d", {28'd0, d}, 32'd0);
    chk("midrst tl", {31'd0, tl}, 32'd1);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(6);
    chk("midrst no pulse", pulses - p0, 32'd0);

    // Randomized frames with random host gaps, input churn and early stops.
    for (int f = 0; f < 8; f++) begin
      int stop;
      flags = 4'($urandom); buttons = 4'($urandom);
      x = 8'($urandom); y = 8'($urandom);
      sf = flags; sb = buttons; sx = x; sy = y;
      stop = $urandom_range(1, 10);
      p0 = pulses;
      for (int i = 0; i < stop; i++) begin
        if (i != 0) begin
          tick($urandom_range(0, 4));
          if ($urandom_range(0, 1) == 1) begin
            flags = 4'($urandom); buttons = 4'($urandom);
            x = 8'($urandom); y = 8'($urandom);
          end
        end
        step(i != 0, $sformatf("rnd%0d.%0d", f, i), model_nib(sf, sb, sx, sy, i));
      end
      tick(3);
      th = 1'b1;
      tick(3);
      chk($sformatf("rnd%0d idle tl", f), {31'd0, tl}, 32'd1);
      chk($sformatf("rnd%0d idle busy", f), {31'd0, busy}, 32'd0);
      tick(3);
      chk($sformatf("rnd%0d pulses", f), pulses - p0, (stop == 10) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/saturn_mouse_port.md
Name: saturn_mouse_port

Overview:
- Downstream consumer of the PS/2 mouse accumulator's flags/buttons/x/y.
- Answers the Saturn peripheral-port 3-wire handshake (TH select, TR request, TL acknowledge) as a Shuttle Mouse.
- Serialises a snapshot of the accumulator as 4-bit nibbles.
- Pulses reset_acc after a complete read, so the accumulator restarts from zero.

Parameters:
ACK_DLY, 8, clocks from a host event to the TL toggle (minimum 1).
TIMEOUT, 16'd50000, clocks without a TR edge in WAIT_HOST before aborting.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
th  in  1  port TH from host, asynchronous, low = device selected
tr  in  1  port TR from host, asynchronous, each edge requests the next nibble
flags  in  4  {y_ov,x_ov,y_sign,x_sign} from accumulator
buttons  in  4  {start,middle,right,left}, active high
x  in  8  accumulated X, two's complement low byte
y  in  8  accumulated Y, two's complement low byte
d  out  4  port data nibble
tl  out  1  port TL acknowledge
reset_acc  out  1  one-clock pulse: accumulator clear request
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE, d=4'h0, tl=1, reset_acc=0, busy=0, idx=0, delay and timeout counters 0, sync flops preset to 1.
- th and tr pass through 2-FF synchronisers. A third flop provides edge detect.
- An event is seen 3 clocks after the pin changes. TL toggles ACK_DLY clocks after the event is seen.
- Snapshot on the TH fall event: S = {0x0, 0xB, 0xF, 0xF, flags, buttons, x[7:4], x[3:0], y[7:4], y[3:0]}, indices 0..9.
- IDLE:
  - d=0, tl=1.
  - TH fall event: capture snapshot, idx=0, d=S[0], load delay counter, go to ACK.
- ACK:
  - Count down ACK_DLY.
  - On expiry: toggle tl.
  - If idx==9, pulse reset_acc for one clock.
  - Clear the timeout counter and go to WAIT_HOST.
- WAIT_HOST:
  - TR edge (either polarity) with idx<9: idx+1, d=S[idx+1], go to ACK.
  - TR edge with idx==9: d=4'h0, idx holds at 9, go to ACK. Surplus acks do not pulse reset_acc again.
  - Timeout counter reaches TIMEOUT: go to ABORT.
- ABORT: d and tl hold; all TR edges are ignored.
- TH rise event in any non-IDLE state has priority over everything:
  - Go to IDLE next clock, tl=1, d=0.
  - reset_acc is not pulsed unless the nibble-9 ack already completed.
- Simultaneous TH rise and TR edge on the same clock: TH rise wins.
- A TR edge arriving while in ACK is latched as one pending request. It is serviced on entry to WAIT_HOST, without a fresh timeout.
  - A second edge arriving during the same ACK is dropped.
- TH fall while already selected cannot occur. TH high→low after IDLE re-entry starts a fresh snapshot.
- The inputs flags/buttons/x/y may change at any time. Only the snapshot is transmitted, so a frame is always coherent.
- reset_acc asserts only after TL for nibble 9 has been driven. The accumulator therefore never loses motion that the host has not received.
- Reset mid-transfer: immediate IDLE values next clock, no reset_acc.

Decomposition:
- Shared package saturn_periph_pkg holds:
  - state enum {IDLE, ACK, WAIT_HOST, ABORT};
  - constant MOUSE_ID nibbles {4'h0,4'hB,4'hF,4'hF};
  - NIBBLES=10.
- Sub-module periph_sync: 2-FF synchroniser plus edge detector, instantiated once each for th and tr. Parameterised reset value 1.
- Snapshot register array and nibble mux stay inline.

Test Plan:
- Reset then idle: reset_n low 2 clocks -> d=0, tl=1, reset_acc=0, busy=0; pin toggles of tr with th=1 leave the outputs unchanged.
- Full read: flags=4'b0101, buttons=4'b0011, x=8'h3C, y=8'hF0; th low, 9 TR toggles each after tl changes -> d sequence 0,B,F,F,5,3,3,C,F,0; tl toggles 10 times, each 3+ACK_DLY clocks after the pin event; exactly one reset_acc pulse, one clock after the 10th tl toggle.
- Coherence: change x to 8'h11 after TH falls -> nibbles 6,7 still carry the snapshot value 8'h3C.
- Early deselect: th rises after nibble 5 -> IDLE within 4 clocks, tl=1, d=0, no reset_acc; next th fall restarts at nibble 0 with d=0.
- Timeout: TIMEOUT=100, host stalls after nibble 2 -> ABORT after 100 clocks; later tr toggles leave d=F and tl unchanged; th rise -> IDLE.
- Overrun and surplus: a second TR edge during ACK is serviced once, and a third within the same ACK is dropped; after nibble 9, two extra toggles -> d=0, tl acks, no further reset_acc.
